irq_request_unit: RTL and testbench

External-interrupt requester that drives the external cause lines `ca[22:7]` consumed by the interrupt controller. It synchronizes asynchronous device interrupt lines and runs a programmable interval timer. It holds each request pending until the CPU acknowledges it (`jisr` together with the matching `mca` bit) or software clears it. It sits between the I/O devices and the cause-vector input of the exception path; software configures it through a small register port.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_sync_edge.sv | 30 +++
 rtl/irq_request_unit.sv | 132 +++++++++++++
 tb/tb_irq_request_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the external-interrupt requester.
// Holds the register map, the cause-vector placement and the timer states.
package irq_pkg;

    localparam logic [2:0] IRQ_PEND  = 3'd0;
    localparam logic [2:0] IRQ_EN    = 3'd1;
    localparam logic [2:0] IRQ_TLOAD = 3'd2;
    localparam logic [2:0] IRQ_TCTRL = 3'd3;
    localparam logic [2:0] IRQ_TCNT  = 3'd4;

    // irq_ca[0] lands on ca[7] of the controller's cause vector
    localparam int CA_EXT_BASE = 7;

    localparam int TCTRL_RUN  = 0;
    localparam int TCTRL_AUTO = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Single-line 2-flop synchronizer followed by a rising-edge detector.
// rise is high for one cycle, two edges after the input is first sampled high.
module irq_sync_edge
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/irq_request_unit.sv
// External-interrupt requester: synchronized device edges and an interval timer
// latch into pending bits that drive the controller's external cause lines.
module irq_request_unit
    import irq_pkg::*;
#(
    parameter int N_DEV   = 15,
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DEV-1:0]   dev_irq,
    input  logic               jisr,
    input  logic [22:0]        mca,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic [N_DEV:0]     irq_ca
);

    logic [N_DEV:0]     pend_reg, pend_next;
    logic [N_DEV:0]     en_reg, en_next;
    logic [TIMER_W-1:0] tload_reg, tload_next;
    logic [1:0]         tctrl_reg, tctrl_next;
    logic [TIMER_W-1:0] cnt_reg, cnt_next;
    timer_state_e       state_reg, state_next;

    logic [N_DEV-1:0]   dev_rise;
    logic               timer_expire;
    logic [N_DEV:0]     clr_mask;
    logic [TIMER_W-1:0] reload_val;
    logic               wr_pend, wr_en, wr_tload, wr_tctrl;
    logic               unused_mca;

    assign unused_mca = ^mca[CA_EXT_BASE-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < N_DEV; gi++) begin : g_dev
            irq_sync_edge u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (dev_irq[gi]),
                .rise  (dev_rise[gi])
            );
        end
    endgenerate

    assign wr_pend  = cfg_we && (cfg_addr == IRQ_PEND);
    assign wr_en    = cfg_we && (cfg_addr == IRQ_EN);
    assign wr_tload = cfg_we && (cfg_addr == IRQ_TLOAD);
    assign wr_tctrl = cfg_we && (cfg_addr == IRQ_TCTRL);

    // A zero reload still gives a one-cycle period.
    assign reload_val = (tload_reg == '0) ? TIMER_W'(1) : tload_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        tctrl_next   = tctrl_reg;
        timer_expire = 1'b0;
        if (wr_tctrl) begin
            tctrl_next = cfg_wdata[1:0];
            if (cfg_wdata[TCTRL_RUN]) begin
                state_next = RUN;
                cnt_next   = reload_val;
            end else begin
                state_next = IDLE;
            end
        end else if (state_reg == RUN) begin
            if (cnt_reg <= TIMER_W'(1)) begin
                timer_expire = 1'b1;
                if (tctrl_reg[TCTRL_AUTO]) begin
                    cnt_next = reload_val;
                end else begin
                    cnt_next              = '0;
                    tctrl_next[TCTRL_RUN] = 1'b0;
                    state_next            = IDLE;
                end
            end else begin
                cnt_next = cnt_reg - TIMER_W'(1);
            end
        end
    end

    // Acknowledge only reaches enabled bits; a new set always beats a clear.
    always_comb begin
        clr_mask = '0;
        if (jisr) begin
            clr_mask = mca[CA_EXT_BASE +: N_DEV+1] & en_reg;
        end
        if (wr_pend) begin
            clr_mask = clr_mask | cfg_wdata[N_DEV:0];
        end
        pend_next  = (pend_reg & ~clr_mask) | {dev_rise, timer_expire};
        en_next    = wr_en ? cfg_wdata[N_DEV:0] : en_reg;
        tload_next = wr_tload ? cfg_wdata[TIMER_W-1:0] : tload_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_reg  <= '0;
            en_reg    <= '0;
            tload_reg <= '0;
            tctrl_reg <= '0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
        end else begin
            pend_reg  <= pend_next;
            en_reg    <= en_next;
            tload_reg <= tload_next;
            tctrl_reg <= tctrl_next;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            IRQ_PEND:  cfg_rdata[N_DEV:0]     = pend_reg;
            IRQ_EN:    cfg_rdata[N_DEV:0]     = en_reg;
            IRQ_TLOAD: cfg_rdata[TIMER_W-1:0] = tload_reg;
            IRQ_TCTRL: cfg_rdata[1:0]         = tctrl_reg;
            IRQ_TCNT:  cfg_rdata[TIMER_W-1:0] = cnt_reg;
            default:   cfg_rdata = '0;
        endcase
    end

    assign irq_ca = pend_reg & en_reg;

endmodule

// File: tb/tb_irq_request_unit.sv
// Scoreboard bench for irq_request_unit: directed scenarios then random traffic,
// each cycle's expected irq_ca and cfg_rdata come from a behavioural model.
module tb_irq_request_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] dev_irq;
    logic        jisr;
    logic [22:0] mca;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [15:0] irq_ca;

    always #5 clk = ~clk;

    irq_request_unit #(.N_DEV(15), .TIMER_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dev_irq   (dev_irq),
        .jisr      (jisr),
        .mca       (mca),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_ca    (irq_ca)
    );

    typedef struct {
        logic [15:0] ca;
        logic [31:0] rd;
        logic [2:0]  addr;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_id   = 0;

    // Behavioural state: pending/enable words, timer "cycles left" and the
    // history of dev_irq as sampled at the last three clock edges.
    logic [15:0] m_pend, m_en;
    logic [31:0] m_tload, m_cnt;
    logic [1:0]  m_tctrl;
    logic [14:0] m_hist[3];
    logic [14:0] dv;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {16'h0, m_pend};
            3'd1:    return {16'h0, m_en};
            3'd2:    return m_tload;
            3'd3:    return {30'h0, m_tctrl};
            3'd4:    return m_cnt;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_step(input logic r, input logic [14:0] d, input logic j,
                                       input logic [22:0] m, input logic we,
                                       input logic [2:0] a, input logic [31:0] wd);
        logic [14:0] rise;
        logic        expire;
        logic [15:0] clr;
        logic [31:0] period;
        if (!r) begin
            m_pend = '0; m_en = '0; m_tload = '0; m_cnt = '0; m_tctrl = '0;
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            return;
        end
        // a line first seen high two edges ago (after being low) becomes pending now
        rise      = m_hist[1] & ~m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = d;
        period = (m_tload == 0) ? 32'd1 : m_tload;
        expire = 1'b0;
        if (we && a == 3'd3) begin
            m_tctrl = wd[1:0];
            if (wd[0]) m_cnt = period;
        end else if (m_tctrl[0]) begin
            if (m_cnt <= 1) begin
                expire = 1'b1;
                if (m_tctrl[1]) m_cnt = period;
                else begin
                    m_cnt = 0;
                    m_tctrl[0] = 1'b0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        clr = '0;
        if (j) clr = m[22:7] & m_en;
        if (we && a == 3'd0) clr = clr | wd[15:0];
        m_pend = (m_pend & ~clr) | {rise, expire};
        if (we && a == 3'd1) m_en = wd[15:0];
        if (we && a == 3'd2) m_tload = wd;
    endfunction

    task automatic cyc(input logic r, input logic [14:0] d, input logic j, input logic [22:0] m,
                       input logic we, input logic [2:0] a, input logic [31:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; dev_irq = d; jisr = j; mca = m;
        cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        e.ca   = m_pend & m_en;
        e.rd   = model_read(a);
        e.addr = a;
        e.id   = cyc_id;
        exp_q.push_back(e);
        cyc_id++;
        model_step(r, d, j, m, we, a, wd);
    endtask

    task automatic idle(input int n, input logic [2:0] a);
        for (int i = 0; i < n; i++) cyc(1'b1, dv, 1'b0, 23'h0, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b1, dv, 1'b0, 23'h0, 1'b1, a, wd);
    endtask

    task automatic ack(input logic [22:0] m, input logic [2:0] a);
        cyc(1'b1, dv, 1'b1, m, 1'b0, a, 32'h0);
    endtask

    // Monitor: outputs are valid every cycle, so each negedge consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (irq_ca !== e.ca) begin
                    n_fail++;
                    $display("FAIL irq_ca cycle %0d: got %h expected %h", e.id, irq_ca, e.ca);
                end
                n_checks++;
                if (cfg_rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL cfg_rdata[addr %0d] cycle %0d: got %h expected %h",
                             e.addr, e.id, cfg_rdata, e.rd);
                end
            end
        end
    end

    initial begin
        logic        r, j, we;
        logic [22:0] m;
        logic [2:0]  a;
        logic [31:0] wd;
        rst_n = 1'b0; dev_irq = '0; jisr = 1'b0; mca = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        dv = '0;
        model_step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);

        // reset state, every address read while held in reset
        for (int i = 0; i < 8; i++) cyc(1'b0, dv, 1'b0, 23'h0, 1'b0, 3'(i), 32'h0);

        // device request and acknowledge of cause bit 11
        wr(3'd1, 32'h0000_FFFF);
        dv = 15'h0008; idle(1, 3'd0);
        dv = 15'h0000; idle(3, 3'd0);
        ack(23'h000800, 3'd0);
        idle(2, 3'd0);

        // masking
        wr(3'd1, 32'h0);
        dv = 15'h0001; idle(1, 3'd0);
        dv = 15'h0000; idle(3, 3'd0);
        ack(23'h7FFF80, 3'd0);
        wr(3'd1, 32'h0000_0002);
        idle(2, 3'd0);
        wr(3'd0, 32'h0000_FFFF);

        // one-shot timer, TLOAD=5 then TLOAD=0
        wr(3'd1, 32'h0000_FFFF);
        wr(3'd2, 32'd5);
        wr(3'd3, 32'h1);
        idle(6, 3'd4);
        idle(1, 3'd3);
        wr(3'd0, 32'h1);
        wr(3'd2, 32'd0);
        wr(3'd3, 32'h1);
        idle(3, 3'd4);
        wr(3'd0, 32'h1);

        // auto-reload, acknowledging the timer bit every cycle
        wr(3'd2, 32'd4);
        wr(3'd3, 32'h3);
        for (int i = 0; i < 14; i++) ack(23'h000080, 3'd4);
        wr(3'd3, 32'h0);
        idle(2, 3'd4);

        // line-2 edge colliding with a W1C of bit 3
        dv = 15'h0004; idle(1, 3'd0);
        idle(1, 3'd0);
        wr(3'd0, 32'h0000_0008);
        idle(1, 3'd0);
        dv = 15'h0000;
        wr(3'd0, 32'h0000_FFFF);

        // reset mid-count with line 5 held high
        wr(3'd2, 32'd20);
        wr(3'd3, 32'h1);
        dv = 15'h0020; idle(4, 3'd4);
        cyc(1'b0, dv, 1'b0, 23'h0, 1'b0, 3'd4, 32'h0);
        idle(1, 3'd0);
        wr(3'd1, 32'h0000_FFFF);
        idle(5, 3'd0);
        dv = 15'h0000;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) != 0);
            dv = dv ^ 15'($urandom & $urandom & $urandom);
            j  = ($urandom_range(0, 3) == 0);
            m  = 23'($urandom & $urandom);
            we = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd0) wd = $urandom & $urandom;
            if (a == 3'd2) wd = $urandom_range(0, 10);
            if (a == 3'd3 && $urandom_range(0, 1) == 1) wd = $urandom_range(0, 3);
            cyc(r, dv, j, m, we, a, wd);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
